reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: MAX_PENDING, default 8, maximum outstanding register writes (legal 1..31).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RSTN  input  1  reset, asynchronous and active-high; asserted when 1.
REQ-004 ISSUE_VALID  input  1  decode presents an instruction for issue.
REQ-005 ISSUE_RS1_IDX / ISSUE_RS1_USE  input  5 / 1  first source register index and its use flag.
REQ-006 ISSUE_RS2_IDX / ISSUE_RS2_USE  input  5 / 1  second source register index and its use flag.
REQ-007 ISSUE_RD_IDX / ISSUE_RD_WE  input  5 / 1  destination register index and its write-enable.
REQ-008 ISSUE_READY  output  1  combinational; instruction may issue this cycle.
REQ-009 STALL  output  1  combinational; ISSUE_VALID & ~ISSUE_READY.
REQ-010 WB_VALID / WB_IDX  input  1 / 5  writeback completion releasing one register.
REQ-011 FLUSH  input  1  branch/redirect; discards all outstanding writes.
REQ-012 BUSY  output  32  registered busy vector; bit n = write to xn pending.
REQ-013 PENDING  output  5  registered count of outstanding writes.
REQ-014 WB_ERR  output  1  registered sticky flag: writeback to a non-busy register.
REQ-015 STALL_CYCLES  output  16  registered saturating stall-cycle counter.

Function
REQ-016 Accept = ISSUE_VALID & ISSUE_READY; on accept with ISSUE_RD_WE and RD != 0, BUSY[RD] sets and PENDING increments at next edge.
REQ-017 "Released" index i this cycle: WB_VALID & WB_IDX == i & BUSY[i].
REQ-018 RAW hazard: RSk_USE & RSk_IDX != 0 & BUSY[RSk_IDX] & not released, for k = 1 or 2.
REQ-019 WAW hazard: ISSUE_RD_WE & RD != 0 & BUSY[RD] & RD not released.
REQ-020 Full: PENDING == MAX_PENDING & no valid release this cycle & ISSUE_RD_WE & RD != 0.
REQ-021 ISSUE_READY = ~FLUSH & ~RAW & ~WAW & ~Full; independent of ISSUE_VALID.
REQ-022 Register x0 never busy; BUSY[0] constant 0; RD = 0 or ~RD_WE does not affect BUSY/PENDING; RSk_IDX = 0 never hazards.
REQ-023 Valid release clears BUSY[WB_IDX] and decrements PENDING at next edge.
REQ-024 Simultaneous release and accept of same index: set wins; BUSY bit stays 1, PENDING unchanged.
REQ-025 Simultaneous release and accept of different indices: both apply; PENDING unchanged.
REQ-026 WB_VALID with WB_IDX == 0 or BUSY[WB_IDX] == 0: no state change except WB_ERR set to 1 (sticky until reset).
REQ-027 FLUSH: next edge BUSY = 0, PENDING = 0; same-cycle issue and writeback ignored; WB_ERR not set by writebacks during FLUSH.
REQ-028 PENDING always equals popcount(BUSY); never exceeds MAX_PENDING; never underflows.
REQ-029 STALL_CYCLES increments when STALL & ~FLUSH; saturates at 0xFFFF; never wraps.
REQ-030 Latency: accept visible in BUSY/PENDING one cycle later; release affects ISSUE_READY same cycle (bypass).

Reset
REQ-031 RSTN = 1 asynchronously forces BUSY = 0, PENDING = 0, WB_ERR = 0, STALL_CYCLES = 0, regardless of CLK.
REQ-032 Reset mid-operation discards all outstanding writes; first edge after RSTN deasserts operates from empty state.
REQ-033 Combinational outputs during reset follow reset state (ISSUE_READY = ~FLUSH).

Verification
REQ-034 Issue RD=5 WE; next cycle issue RS1=5 USE -> STALL=1, BUSY=0x00000020, PENDING=1, STALL_CYCLES counts 1,2,...; WB_VALID WB_IDX=5 -> ISSUE_READY=1 same cycle, BUSY=0 and PENDING=0 next edge.
REQ-035 Issue 8 writes RD=1..8 (MAX_PENDING=8) -> PENDING=8; issue RD=9 WE -> STALL=1; same cycle WB_IDX=1 -> accept, BUSY=0x000003FC, PENDING=8.
REQ-036 BUSY[3]=1; WB_IDX=3 with issue RD=3 WE same cycle -> BUSY[3]=1, PENDING unchanged, no stall.
REQ-037 WB_VALID WB_IDX=7 with BUSY[7]=0, and WB_IDX=0 -> BUSY/PENDING unchanged, WB_ERR=1 and held.
REQ-038 Four pending writes, FLUSH=1 with concurrent issue RD=10 -> ISSUE_READY=0, next edge BUSY=0, PENDING=0, BUSY[10]=0.
REQ-039 RSTN pulsed 1 between clock edges with PENDING=3, STALL_CYCLES=0x0010 -> all registered outputs 0 immediately; issue RD=0 WE -> PENDING stays 0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard tracking outstanding writes for in-order issue
module reg_scoreboard #(
  parameter int MAX_PENDING = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rs1_idx_i,
  input  logic        issue_rs1_use_i,
  input  logic [4:0]  issue_rs2_idx_i,
  input  logic        issue_rs2_use_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic        issue_rd_we_i,
  output logic        issue_ready_o,
  output logic        stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_idx_i,
  input  logic        flush_i,
  output logic [31:0] busy_o,
  output logic [4:0]  pending_o,
  output logic        wb_err_o,
  output logic [15:0] stall_cycles_o
);

  logic [31:0] busy_q, busy_d;
  logic [4:0]  pending_q, pending_d;
  logic        wb_err_q, wb_err_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic wb_hit;
  logic raw1, raw2, waw, full;
  logic rd_writes;
  logic accept;
  logic set_en;

  // Hazard detection with writeback bypass: a register released this cycle no longer blocks issue
  always_comb begin
    // busy_q[0] is always 0, so a writeback to x0 never counts as a release
    wb_hit    = wb_valid_i & busy_q[wb_idx_i];
    rd_writes = issue_rd_we_i & (issue_rd_idx_i != 5'd0);

    raw1 = issue_rs1_use_i & (issue_rs1_idx_i != 5'd0) & busy_q[issue_rs1_idx_i]
           & ~(wb_hit & (wb_idx_i == issue_rs1_idx_i));
    raw2 = issue_rs2_use_i & (issue_rs2_idx_i != 5'd0) & busy_q[issue_rs2_idx_i]
           & ~(wb_hit & (wb_idx_i == issue_rs2_idx_i));
    waw  = rd_writes & busy_q[issue_rd_idx_i]
           & ~(wb_hit & (wb_idx_i == issue_rd_idx_i));
    full = (pending_q == 5'(MAX_PENDING)) & ~wb_hit & rd_writes;

    issue_ready_o = ~flush_i & ~raw1 & ~raw2 & ~waw & ~full;
    stall_o       = issue_valid_i & ~issue_ready_o;
    accept        = issue_valid_i & issue_ready_o;
    set_en        = accept & rd_writes;
  end

  // Next-state: release clears, accept sets (set wins on same index), flush empties everything
  always_comb begin
    busy_d         = busy_q;
    pending_d      = pending_q;
    wb_err_d       = wb_err_q;
    stall_cycles_d = stall_cycles_q;

    if (flush_i) begin
      busy_d    = 32'd0;
      pending_d = 5'd0;
    end else begin
      if (wb_hit) begin
        busy_d[wb_idx_i] = 1'b0;
      end
      if (set_en) begin
        busy_d[issue_rd_idx_i] = 1'b1;
      end
      busy_d[0]  = 1'b0;
      pending_d  = pending_q + 5'(set_en) - 5'(wb_hit);
      if (wb_valid_i && !wb_hit) begin
        wb_err_d = 1'b1;
      end
      if (stall_o && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_d = stall_cycles_q + 16'd1;
      end
    end
  end

  // State registers, cleared asynchronously on reset
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      busy_q         <= 32'd0;
      pending_q      <= 5'd0;
      wb_err_q       <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      busy_q         <= busy_d;
      pending_q      <= pending_d;
      wb_err_q       <= wb_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign busy_o         = busy_q;
  assign pending_o      = pending_q;
  assign wb_err_o       = wb_err_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic        rs1_use, rs2_use, rd_we;
  logic        issue_ready, stall;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic        flush;
  logic [31:0] busy;
  logic [4:0]  pending;
  logic        wb_err;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  reg_scoreboard #(.MAX_PENDING(8)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .issue_valid_i  (issue_valid),
    .issue_rs1_idx_i(rs1_idx),
    .issue_rs1_use_i(rs1_use),
    .issue_rs2_idx_i(rs2_idx),
    .issue_rs2_use_i(rs2_use),
    .issue_rd_idx_i (rd_idx),
    .issue_rd_we_i  (rd_we),
    .issue_ready_o  (issue_ready),
    .stall_o        (stall),
    .wb_valid_i     (wb_valid),
    .wb_idx_i       (wb_idx),
    .flush_i        (flush),
    .busy_o         (busy),
    .pending_o      (pending),
    .wb_err_o       (wb_err),
    .stall_cycles_o (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 1'b0;
    rs1_idx = 5'd0; rs1_use = 1'b0;
    rs2_idx = 5'd0; rs2_use = 1'b0;
    rd_idx  = 5'd0; rd_we   = 1'b0;
    wb_valid = 1'b0; wb_idx = 5'd0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1; rd_idx = rd; rd_we = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b1;
    tick();
    tick();
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=%h", busy, 32'd0); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall_cycles got=%h exp=0", stall_cycles); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    flush = 1'b1;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_flush got=%b exp=0", issue_ready); end
    flush = 1'b0;
    rstn = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    idle();
    issue_valid = 1'b1; rd_idx = 5'd5; rd_we = 1'b1;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_first_ready got=%b exp=1", issue_ready); end
    tick();
    total++; if (busy !== 32'h0000_0020) begin bad++; $display("FAIL raw_busy got=%h exp=%h", busy, 32'h20); end
    total++; if (pending !== 5'd1) begin bad++; $display("FAIL raw_pending got=%0d exp=1", pending); end
    idle();
    issue_valid = 1'b1; rs1_idx = 5'd5; rs1_use = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", stall); end
    tick();
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL raw_stall_cnt1 got=%0d exp=1", stall_cycles); end
    tick();
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL raw_stall_cnt2 got=%0d exp=2", stall_cycles); end
    wb_valid = 1'b1; wb_idx = 5'd5;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_bypass_ready got=%b exp=1", issue_ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_bypass_stall got=%b exp=0", stall); end
    tick();
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL raw_release_busy got=%h exp=0", busy); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL raw_release_pending got=%0d exp=0", pending); end
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL raw_stall_hold got=%0d exp=2", stall_cycles); end
    idle();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 8; i++) issue_wr(5'(i));
    idle();
    total++; if (pending !== 5'd8) begin bad++; $display("FAIL full_pending got=%0d exp=8", pending); end
    total++; if (busy !== 32'h0000_01FE) begin bad++; $display("FAIL full_busy got=%h exp=%h", busy, 32'h1FE); end
    issue_valid = 1'b1; rd_idx = 5'd9; rd_we = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", stall); end
    wb_valid = 1'b1; wb_idx = 5'd1;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_release_ready got=%b exp=1", issue_ready); end
    tick();
    total++; if (busy !== 32'h0000_03FC) begin bad++; $display("FAIL full_swap_busy got=%h exp=%h", busy, 32'h3FC); end
    total++; if (pending !== 5'd8) begin bad++; $display("FAIL full_swap_pending got=%0d exp=8", pending); end
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL full_stall_cnt got=%0d exp=2", stall_cycles); end
    idle();
  endtask

  task automatic test_same_idx();
    idle();
    issue_valid = 1'b1; rd_idx = 5'd3; rd_we = 1'b1;
    wb_valid = 1'b1; wb_idx = 5'd3;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL same_stall got=%b exp=0", stall); end
    tick();
    total++; if (busy !== 32'h0000_03FC) begin bad++; $display("FAIL same_busy got=%h exp=%h", busy, 32'h3FC); end
    total++; if (pending !== 5'd8) begin bad++; $display("FAIL same_pending got=%0d exp=8", pending); end
    idle();
  endtask

  task automatic test_diff_idx();
    idle();
    issue_valid = 1'b1; rd_idx = 5'd12; rd_we = 1'b1;
    wb_valid = 1'b1; wb_idx = 5'd2;
    tick();
    total++; if (busy !== 32'h0000_13F8) begin bad++; $display("FAIL diff_busy got=%h exp=%h", busy, 32'h13F8); end
    total++; if (pending !== 5'd8) begin bad++; $display("FAIL diff_pending got=%0d exp=8", pending); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL diff_wb_err got=%b exp=0", wb_err); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    flush = 1'b1;
    tick();
    idle();
    for (int i = 1; i <= 4; i++) issue_wr(5'(i));
    idle();
    total++; if (pending !== 5'd4) begin bad++; $display("FAIL flush_pre_pending got=%0d exp=4", pending); end
    flush = 1'b1;
    issue_valid = 1'b1; rd_idx = 5'd10; rd_we = 1'b1;
    wb_valid = 1'b1; wb_idx = 5'd20;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
    tick();
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL flush_busy got=%h exp=0", busy); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL flush_pending got=%0d exp=0", pending); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL flush_wb_err got=%b exp=0", wb_err); end
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL flush_stall_cnt got=%0d exp=2", stall_cycles); end
    idle();
  endtask

  task automatic test_wb_err();
    idle();
    wb_valid = 1'b1; wb_idx = 5'd7;
    tick();
    idle();
    total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", wb_err); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL err_busy got=%h exp=0", busy); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL err_pending got=%0d exp=0", pending); end
    wb_valid = 1'b1; wb_idx = 5'd0;
    tick();
    idle();
    tick();
    total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_held got=%b exp=1", wb_err); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL err_x0_pending got=%0d exp=0", pending); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) issue_wr(5'(i));
    idle();
    issue_valid = 1'b1; rs1_idx = 5'd1; rs1_use = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    idle();
    total++; if (stall_cycles !== 16'h0010) begin bad++; $display("FAIL ar_pre_stall_cnt got=%h exp=%h", stall_cycles, 16'h10); end
    total++; if (pending !== 5'd3) begin bad++; $display("FAIL ar_pre_pending got=%0d exp=3", pending); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL ar_busy got=%h exp=0", busy); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL ar_pending got=%0d exp=0", pending); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL ar_wb_err got=%b exp=0", wb_err); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL ar_stall_cnt got=%h exp=0", stall_cycles); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b exp=1", issue_ready); end
    #1;
    rstn = 1'b0;
    issue_valid = 1'b1; rd_idx = 5'd0; rd_we = 1'b1;
    tick();
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL ar_x0_pending got=%0d exp=0", pending); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL ar_x0_busy got=%h exp=0", busy); end
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b1;
    test_reset();
    test_raw();
    test_full();
    test_same_idx();
    test_diff_idx();
    test_flush();
    test_wb_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
